// File: rtl/sdrc_tg_pkg.sv
// Shared FSM encoding and Wishbone cycle-type constants for the SDRAM
// traffic-generator burst master.
package sdrc_tg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } tg_state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_tg_checker.sv
// Read-beat checker: registers each acked read word and keeps a saturating
// count of words that differ from the expected pattern.
module wb_tg_checker #(
   parameter int dw = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          beat,
   input  logic [dw-1:0] rd_in,
   input  logic [dw-1:0] expected,
   input  logic          err_clr,
   output logic          rd_valid,
   output logic [dw-1:0] rd_data,
   output logic [15:0]   err_cnt
);

   logic mismatch;

   assign mismatch = beat && (rd_in != expected);

   // Read-data capture and mismatch counter; a clear that lands on a mismatch leaves 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         err_cnt  <= 16'h0000;
      end else begin
         rd_valid <= beat;
         if (beat) begin
            rd_data <= rd_in;
         end
         if (err_clr) begin
            err_cnt <= mismatch ? 16'h0001 : 16'h0000;
         end else if (mismatch && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'h0001;
         end
      end
   end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst traffic master: issues linear incrementing bursts with a
// counting data pattern and checks read bursts against the same pattern.
module wb_burst_master
   import sdrc_tg_pkg::*;
#(
   parameter int dw         = 32,
   parameter int app_addr_w = 26,
   parameter int len_w      = 8,
   parameter int to_cycles  = 1024
) (
   input  logic                  sys_clk,
   input  logic                  wb_rst_i,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [app_addr_w-1:0] cmd_addr,
   input  logic [len_w-1:0]      cmd_len,
   input  logic [dw-1:0]         cmd_seed,
   input  logic                  err_clr,
   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [app_addr_w-1:0] wb_addr_o,
   output logic [dw-1:0]         wb_dat_o,
   output logic [dw/8-1:0]       wb_sel_o,
   output logic [2:0]            wb_cti_o,
   output logic [1:0]            wb_bte_o,
   input  logic                  wb_ack_i,
   input  logic [dw-1:0]         wb_dat_i,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic                  rd_valid,
   output logic [dw-1:0]         rd_data,
   output logic [15:0]           err_cnt
);

   localparam int                    WD_W       = $clog2(to_cycles + 1);
   localparam logic [WD_W-1:0]       WD_LAST    = WD_W'(to_cycles - 1);
   localparam logic [app_addr_w-1:0] ADDR_STEP  = app_addr_w'(dw / 8);
   localparam logic [app_addr_w-1:0] ALIGN_MASK = ~app_addr_w'(dw / 8 - 1);

   tg_state_t             state;
   logic                  cmd_ready_r;
   logic                  cyc_r;
   logic                  we_r;
   logic [2:0]            cti_r;
   logic [app_addr_w-1:0] addr_r;
   logic [dw-1:0]         pat_r;
   logic [len_w-1:0]      cnt_r;
   logic [WD_W-1:0]       wd_r;
   logic                  done_r;
   logic                  timeout_r;
   logic                  rd_beat;

   assign cmd_ready = cmd_ready_r;
   assign busy      = ~cmd_ready_r;
   assign wb_cyc_o  = cyc_r;
   assign wb_stb_o  = cyc_r;
   assign wb_we_o   = we_r;
   assign wb_addr_o = addr_r;
   assign wb_dat_o  = pat_r;
   assign wb_sel_o  = {(dw/8){cyc_r}};
   assign wb_cti_o  = cti_r;
   assign wb_bte_o  = BTE_LINEAR;
   assign done      = done_r;
   assign timeout   = timeout_r;

   assign rd_beat = (state == BURST) && wb_ack_i && !we_r;

   // Command FSM with burst counters and ack watchdog; bus outputs are registered alongside state.
   always_ff @(posedge sys_clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         cmd_ready_r <= 1'b1;
         cyc_r       <= 1'b0;
         we_r        <= 1'b0;
         cti_r       <= CTI_CLASSIC;
         addr_r      <= '0;
         pat_r       <= '0;
         cnt_r       <= '0;
         wd_r        <= '0;
         done_r      <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  state       <= BURST;
                  cmd_ready_r <= 1'b0;
                  cyc_r       <= 1'b1;
                  we_r        <= cmd_we;
                  cti_r       <= (cmd_len == '0) ? CTI_EOB : CTI_INCR;
                  addr_r      <= cmd_addr & ALIGN_MASK;
                  pat_r       <= cmd_seed;
                  cnt_r       <= cmd_len;
                  wd_r        <= '0;
                  timeout_r   <= 1'b0;
               end
            end
            BURST: begin
               if (wb_ack_i) begin
                  wd_r <= '0;
                  if (cnt_r == '0) begin
                     state  <= DONE;
                     cyc_r  <= 1'b0;
                     we_r   <= 1'b0;
                     cti_r  <= CTI_CLASSIC;
                     done_r <= 1'b1;
                  end else begin
                     addr_r <= addr_r + ADDR_STEP;
                     pat_r  <= pat_r + dw'(1);
                     cnt_r  <= cnt_r - len_w'(1);
                     cti_r  <= (cnt_r == len_w'(1)) ? CTI_EOB : CTI_INCR;
                  end
               end else if (wd_r == WD_LAST) begin
                  // Slave stopped answering: abandon the rest of the burst.
                  state     <= DONE;
                  cyc_r     <= 1'b0;
                  we_r      <= 1'b0;
                  cti_r     <= CTI_CLASSIC;
                  done_r    <= 1'b1;
                  timeout_r <= 1'b1;
               end else begin
                  wd_r <= wd_r + WD_W'(1);
               end
            end
            DONE: begin
               state       <= IDLE;
               cmd_ready_r <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               cmd_ready_r <= 1'b1;
               cyc_r       <= 1'b0;
               we_r        <= 1'b0;
               cti_r       <= CTI_CLASSIC;
            end
         endcase
      end
   end

   wb_tg_checker #(
      .dw(dw)
   ) u_checker (
      .clk      (sys_clk),
      .rst      (wb_rst_i),
      .beat     (rd_beat),
      .rd_in    (wb_dat_i),
      .expected (pat_r),
      .err_clr  (err_clr),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .err_cnt  (err_cnt)
   );

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: a behavioural Wishbone slave acks beats,
// expected beats and read words are queued up front and popped as they occur.
module tb_wb_burst_master;

   localparam int DW = 32;
   localparam int AW = 26;
   localparam int LW = 8;
   localparam int TO = 1024;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
      logic [2:0]    cti;
      logic          we;
   } beat_t;

   logic          sys_clk = 1'b0;
   logic          wb_rst_i = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_we = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic [DW-1:0] cmd_seed = '0;
   logic          err_clr = 1'b0;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [AW-1:0] wb_addr_o;
   logic [DW-1:0] wb_dat_o;
   logic [DW/8-1:0] wb_sel_o;
   logic [2:0]    wb_cti_o;
   logic [1:0]    wb_bte_o;
   logic          wb_ack_i = 1'b0;
   logic [DW-1:0] wb_dat_i = '0;
   logic          busy, done, timeout, rd_valid;
   logic [DW-1:0] rd_data;
   logic [15:0]   err_cnt;

   beat_t         sb[$];
   logic [DW-1:0] rdq[$];
   logic [DW-1:0] rd_table[0:15];

   int checks = 0;
   int errors = 0;
   int cyc_count = 0;
   int ack_delay = 0;
   int ack_limit = 1000;
   int beat_idx = 0;
   int stall = 0;
   int stall_run = 0;
   int acks = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int first_ack_cyc = 0;
   int last_ack_cyc = 0;
   int rd_cnt = 0;

   wb_burst_master #(.dw(DW), .app_addr_w(AW), .len_w(LW), .to_cycles(TO)) dut (
      .sys_clk(sys_clk), .wb_rst_i(wb_rst_i),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed), .err_clr(err_clr),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
      .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
      .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
      .busy(busy), .done(done), .timeout(timeout),
      .rd_valid(rd_valid), .rd_data(rd_data), .err_cnt(err_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   // Advance one cycle; at the falling edge score read data, then play the slave and score the beat.
   task automatic tick();
      beat_t e;
      logic [DW-1:0] r;
      @(negedge sys_clk);
      cyc_count++;
      if (rd_valid) begin
         rd_cnt++;
         checks++;
         if (rdq.size() == 0) begin
            errors++;
            $display("FAIL rd_extra rd_data=%h expected no read strobe", rd_data);
         end else begin
            r = rdq.pop_front();
            if (rd_data !== r) begin
               errors++;
               $display("FAIL rd_data got %h expected %h", rd_data, r);
            end
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc_count;
      end
      if (wb_cyc_o && wb_stb_o) begin
         if (stall >= ack_delay && beat_idx < ack_limit) begin
            wb_ack_i = 1'b1;
            wb_dat_i = rd_table[beat_idx % 16];
            if (!wb_we_o) rdq.push_back(rd_table[beat_idx % 16]);
            if (beat_idx == 0) first_ack_cyc = cyc_count;
            last_ack_cyc = cyc_count;
            beat_idx++;
            acks++;
            stall = 0;
            stall_run = 0;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL beat_extra addr=%h expected no beat", wb_addr_o);
            end else begin
               e = sb.pop_front();
               checks++;
               if (wb_addr_o !== e.addr) begin
                  errors++;
                  $display("FAIL beat_addr got %h expected %h", wb_addr_o, e.addr);
               end
               checks++;
               if (wb_cti_o !== e.cti) begin
                  errors++;
                  $display("FAIL beat_cti got %b expected %b (addr %h)", wb_cti_o, e.cti, e.addr);
               end
               checks++;
               if (wb_we_o !== e.we) begin
                  errors++;
                  $display("FAIL beat_we got %b expected %b", wb_we_o, e.we);
               end
               checks++;
               if (e.we && wb_dat_o !== e.dat) begin
                  errors++;
                  $display("FAIL beat_dat got %h expected %h", wb_dat_o, e.dat);
               end
               checks++;
               if (wb_sel_o !== 4'hF || wb_bte_o !== 2'b00) begin
                  errors++;
                  $display("FAIL beat_sel_bte got %h/%b expected f/00", wb_sel_o, wb_bte_o);
               end
            end
         end else begin
            wb_ack_i = 1'b0;
            stall++;
            stall_run++;
         end
      end else begin
         wb_ack_i = 1'b0;
         stall = 0;
         beat_idx = 0;
      end
   endtask

   task automatic push_burst(input logic we, input logic [AW-1:0] a, input int len,
                             input logic [DW-1:0] seed);
      beat_t b;
      for (int i = 0; i <= len; i++) begin
         b.addr = a + AW'(4 * i);
         b.dat  = seed + DW'(i);
         b.cti  = (i == len) ? 3'b111 : 3'b010;
         b.we   = we;
         sb.push_back(b);
      end
   endtask

   task automatic issue_cmd(input logic we, input logic [AW-1:0] a, input int len,
                            input logic [DW-1:0] seed);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready_idle got %b expected 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = a;
      cmd_len   = LW'(len);
      cmd_seed  = seed;
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (wb_cyc_o !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL cmd_latency cyc=%b busy=%b ready=%b expected 1 1 0", wb_cyc_o, busy, cmd_ready);
      end
   endtask

   task automatic wait_done(input int budget);
      int start;
      start = done_cnt;
      for (int i = 0; i < budget && done_cnt == start; i++) tick();
      checks++;
      if (done_cnt == start) begin
         errors++;
         $display("FAIL done_wait no done within %0d cycles expected a done pulse", budget);
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (sb.size() != 0 || rdq.size() != 0) begin
         errors++;
         $display("FAIL %s_drained beats_left=%0d reads_left=%0d expected 0 0", name, sb.size(), rdq.size());
      end
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      tick();
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl ready=%b cyc=%b stb=%b busy=%b expected 1 0 0 0", cmd_ready, wb_cyc_o, wb_stb_o, busy);
      end
      checks++;
      if (done !== 1'b0 || timeout !== 1'b0 || rd_valid !== 1'b0 || err_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_status done=%b timeout=%b rd_valid=%b err=%h expected 0 0 0 0", done, timeout, rd_valid, err_cnt);
      end
      checks++;
      if (wb_sel_o !== 4'h0 || wb_cti_o !== 3'b000 || wb_addr_o !== 26'h0 || wb_we_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_bus sel=%h cti=%b addr=%h we=%b expected 0 000 0 0", wb_sel_o, wb_cti_o, wb_addr_o, wb_we_o);
      end
      wb_rst_i = 1'b0;
      tick();
      checks++;
      if (cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release ready=%b cyc=%b expected 1 0", cmd_ready, wb_cyc_o);
      end
   endtask

   task automatic test_single_write();
      int a0;
      a0 = acks;
      ack_delay = 2;
      sb.push_back('{addr: 26'h100, dat: 32'hA5A50000, cti: 3'b111, we: 1'b1});
      issue_cmd(1'b1, 26'h100, 0, 32'hA5A50000);
      wait_done(20);
      checks++;
      if (acks - a0 != 1) begin
         errors++;
         $display("FAIL single_beats got %0d expected 1", acks - a0);
      end
      checks++;
      if (done_cyc - last_ack_cyc != 1) begin
         errors++;
         $display("FAIL single_done_lat got %0d expected 1", done_cyc - last_ack_cyc);
      end
      checks++;
      if (wb_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL single_cyc_drop got %b expected 0", wb_cyc_o);
      end
      tick();
      checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_done_pulse done=%b ready=%b expected 0 1", done, cmd_ready);
      end
      check_drained("single");
      ack_delay = 0;
   endtask

   task automatic test_back_to_back();
      int a0;
      a0 = acks;
      push_burst(1'b1, 26'h0, 7, 32'h0);
      issue_cmd(1'b1, 26'h0, 7, 32'h0);
      wait_done(40);
      checks++;
      if (acks - a0 != 8 || last_ack_cyc - first_ack_cyc != 7) begin
         errors++;
         $display("FAIL b2b_beats got %0d beats over %0d cycles expected 8 over 7", acks - a0, last_ack_cyc - first_ack_cyc);
      end
      check_drained("b2b");
      tick();
   endtask

   task automatic test_read_check();
      int r0;
      rd_table[0] = 32'h0;
      rd_table[1] = 32'h1;
      rd_table[2] = 32'hDEAD;
      rd_table[3] = 32'h3;
      for (int k = 0; k < 2; k++) begin
         r0 = rd_cnt;
         push_burst(1'b0, 26'h40, 3, 32'h0);
         issue_cmd(1'b0, 26'h40, 3, 32'h0);
         wait_done(40);
         checks++;
         if (rd_cnt - r0 != 4) begin
            errors++;
            $display("FAIL read_strobes got %0d expected 4", rd_cnt - r0);
         end
         checks++;
         if (err_cnt !== 16'(k + 1)) begin
            errors++;
            $display("FAIL read_err_cnt got %0d expected %0d", err_cnt, k + 1);
         end
         check_drained("read");
         tick();
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (err_cnt !== 16'h0) begin
         errors++;
         $display("FAIL err_clr got %0d expected 0", err_cnt);
      end
      // Hold err_clr through a burst whose last word mismatches.
      push_burst(1'b0, 26'h80, 2, 32'h0);
      err_clr = 1'b1;
      issue_cmd(1'b0, 26'h80, 2, 32'h0);
      for (int i = 0; i < 20 && beat_idx < 3; i++) tick();
      tick();
      err_clr = 1'b0;
      checks++;
      if (err_cnt !== 16'h1 || done !== 1'b1) begin
         errors++;
         $display("FAIL err_clr_collide err=%0d done=%b expected 1 1", err_cnt, done);
      end
      check_drained("collide");
      tick();
   endtask

   task automatic test_addr_wrap();
      sb.push_back('{addr: 26'h3FFFFF8, dat: 32'h10, cti: 3'b010, we: 1'b1});
      sb.push_back('{addr: 26'h3FFFFFC, dat: 32'h11, cti: 3'b010, we: 1'b1});
      sb.push_back('{addr: 26'h0000000, dat: 32'h12, cti: 3'b010, we: 1'b1});
      sb.push_back('{addr: 26'h0000004, dat: 32'h13, cti: 3'b111, we: 1'b1});
      issue_cmd(1'b1, 26'h3FFFFFA, 3, 32'h10);
      wait_done(30);
      check_drained("wrap");
      tick();
   endtask

   task automatic test_watchdog();
      ack_limit = 1;
      sb.push_back('{addr: 26'h200, dat: 32'h7, cti: 3'b010, we: 1'b1});
      issue_cmd(1'b1, 26'h200, 3, 32'h7);
      wait_done(TO + 100);
      checks++;
      if (stall_run != TO) begin
         errors++;
         $display("FAIL wd_stall_cycles got %0d expected %0d", stall_run, TO);
      end
      checks++;
      if (timeout !== 1'b1 || wb_cyc_o !== 1'b0 || err_cnt !== 16'h1) begin
         errors++;
         $display("FAIL wd_abort timeout=%b cyc=%b err=%0d expected 1 0 1", timeout, wb_cyc_o, err_cnt);
      end
      ack_limit = 1000;
      tick();
      tick();
      checks++;
      if (timeout !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL wd_sticky timeout=%b done=%b expected 1 0", timeout, done);
      end
      check_drained("wd");
      sb.push_back('{addr: 26'h300, dat: 32'h9, cti: 3'b111, we: 1'b1});
      issue_cmd(1'b1, 26'h300, 0, 32'h9);
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL wd_clear got %b expected 0", timeout);
      end
      wait_done(20);
      check_drained("wd_next");
      tick();
   endtask

   task automatic test_reset_mid_burst();
      int d0;
      checks++;
      if (err_cnt !== 16'h1) begin
         errors++;
         $display("FAIL rst_pre_err got %0d expected 1", err_cnt);
      end
      push_burst(1'b1, 26'h0, 7, 32'h100);
      d0 = done_cnt;
      issue_cmd(1'b1, 26'h0, 7, 32'h100);
      for (int i = 0; i < 20 && beat_idx < 3; i++) tick();
      #1 wb_rst_i = 1'b1;
      #1;
      checks++;
      if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_async cyc=%b stb=%b ready=%b busy=%b expected 0 0 1 0", wb_cyc_o, wb_stb_o, cmd_ready, busy);
      end
      checks++;
      if (err_cnt !== 16'h0 || done !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL rst_status err=%0d done=%b timeout=%b expected 0 0 0", err_cnt, done, timeout);
      end
      sb.delete();
      tick();
      tick();
      wb_rst_i = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL rst_no_done got %0d done pulses expected 0", done_cnt - d0);
      end
      push_burst(1'b1, 26'h20, 1, 32'h55);
      issue_cmd(1'b1, 26'h20, 1, 32'h55);
      wait_done(20);
      check_drained("rst_recover");
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rd_table[i] = DW'(i);
      test_reset();
      test_single_write();
      test_back_to_back();
      test_read_check();
      test_addr_wrap();
      test_watchdog();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout simulation exceeded time limit expected completion");
      $fatal(1, "bench time limit");
   end

endmodule
